// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and line levels.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Parity bit from the XOR-reduction of the data word: even parity sends the
    // reduction itself, odd parity sends its complement.
    function automatic logic parity_bit(input parity_t mode, input logic data_xor);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words ahead of the UART serialiser.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // Next pointers and occupancy; a push into a full FIFO is refused even when a pop
    // frees a slot on the same edge, because ready was already low in that cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // leaves a value held and no latch is inferred.
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rstN) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the count and pointers
        // define which entries are valid, so flushing them empties the FIFO.
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO front end feeding a start/data/parity/stop serialiser
// paced by an oversampling baud tick.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int      DATA_WIDTH = 8,
    parameter int      OVERSAMPLE = 16,
    parameter int      FIFO_DEPTH = 4,
    parameter parity_t PARITY     = PARITY_NONE,
    parameter int      STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          baudTick,
    input  logic [DATA_WIDTH-1:0]         dataIn,
    input  logic                          txValid,
    output logic                          txReady,
    output logic                          tx,
    output logic                          txBusy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    tx_state_t             state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  bit_end, start_frame;

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (txValid),
        .pop   (fifo_pop),
        .wdata (dataIn),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifoCount)
    );

    assign txReady = !fifo_full;
    assign tx      = tx_q;
    assign txBusy  = busy_q;

    // Next-state logic: bit timing, frame sequencing and the next line level.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        // A bit ends on the edge that registers its OVERSAMPLE-th tick; ticks are
        // ignored while idle so the first bit always gets a full count.
        bit_end = (state_q != ST_IDLE) && baudTick &&
                  (tick_q == TICK_W'(OVERSAMPLE - 1));
        if ((state_q != ST_IDLE) && baudTick) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d        = LINE_IDLE;
                start_frame = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            stop_d  = 1'b0;
                            tx_d    = STOP_LEVEL;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                    tx_d    = STOP_LEVEL;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when data is waiting.
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = LINE_IDLE;
                        end
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase

        // Pop a word and latch its parity; the start bit is driven from the next edge.
        if (start_frame) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            par_d    = parity_bit(PARITY, ^fifo_rdata);
            tick_d   = '0;
            tx_d     = START_LEVEL;
            state_d  = ST_START;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, counters, shift register and registered line/busy outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: four configurations share clock and reset.
//   inst 0: 8N1, OVERSAMPLE 16, tick every 4 clk
//   inst 1: 7 data bits, even parity, OVERSAMPLE 4, tick every 4 clk
//   inst 2: 8 data bits, odd parity, 2 stop bits, OVERSAMPLE 4, tick every 4 clk
//   inst 3: 8N1, OVERSAMPLE 2, tick held high
module tb_uart_tx_buffered;
    import uart_pkg::*;

    typedef struct {
        int          inst;
        logic [15:0] bits;   // bit i is the i-th line level of the frame
        int          len;
    } frame_t;

    localparam int OS_OF [4] = '{16, 4, 4, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bt_slow = 1'b0;
    logic [1:0] div = 2'd0;
    logic [7:0] din_a = '0, din_c = '0, din_d = '0;
    logic [6:0] din_b = '0;
    logic [3:0] val = '0;
    logic [3:0] rdy, tx, busy;
    logic [2:0] cnt [4];

    frame_t exp_q[$];
    int     total = 0;
    int     bad = 0;
    int     frames_done = 0;

    bit          m_act [4] = '{0, 0, 0, 0};
    int          m_idx [4] = '{0, 0, 0, 0};
    int          m_cnt [4] = '{0, 0, 0, 0};
    int          m_len [4] = '{1, 1, 1, 1};
    logic [15:0] m_bits [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

    always #5 clk = ~clk;

    // Tick divider: one-clock pulse every 4 clocks, changed on the falling edge.
    always @(negedge clk) begin
        div = div + 2'd1;
        bt_slow = (div == 2'd0);
    end

    uart_tx_buffered #(.DATA_WIDTH(8), .OVERSAMPLE(16), .FIFO_DEPTH(4),
                       .PARITY(PARITY_NONE), .STOP_BITS(1)) u_a (
        .clk(clk), .rstN(rst_n), .baudTick(bt_slow), .dataIn(din_a), .txValid(val[0]),
        .txReady(rdy[0]), .tx(tx[0]), .txBusy(busy[0]), .fifoCount(cnt[0]));

    uart_tx_buffered #(.DATA_WIDTH(7), .OVERSAMPLE(4), .FIFO_DEPTH(4),
                       .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_b (
        .clk(clk), .rstN(rst_n), .baudTick(bt_slow), .dataIn(din_b), .txValid(val[1]),
        .txReady(rdy[1]), .tx(tx[1]), .txBusy(busy[1]), .fifoCount(cnt[1]));

    uart_tx_buffered #(.DATA_WIDTH(8), .OVERSAMPLE(4), .FIFO_DEPTH(4),
                       .PARITY(PARITY_ODD), .STOP_BITS(2)) u_c (
        .clk(clk), .rstN(rst_n), .baudTick(bt_slow), .dataIn(din_c), .txValid(val[2]),
        .txReady(rdy[2]), .tx(tx[2]), .txBusy(busy[2]), .fifoCount(cnt[2]));

    uart_tx_buffered #(.DATA_WIDTH(8), .OVERSAMPLE(2), .FIFO_DEPTH(4),
                       .PARITY(PARITY_NONE), .STOP_BITS(1)) u_d (
        .clk(clk), .rstN(rst_n), .baudTick(1'b1), .dataIn(din_d), .txValid(val[3]),
        .txReady(rdy[3]), .tx(tx[3]), .txBusy(busy[3]), .fifoCount(cnt[3]));

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic bt_of(input int k);
        return (k == 3) ? 1'b1 : bt_slow;
    endfunction

    // Monitor: follows each line, counting ticks like a receiver, and compares every
    // clock's line level with the expected frame popped from the scoreboard.
    task automatic mon_step(input int k);
        frame_t f;
        if (!rst_n) begin
            m_act[k] = 0;
            return;
        end
        if (m_act[k]) begin
            if (bt_of(k)) m_cnt[k]++;
            if (m_cnt[k] == OS_OF[k]) begin
                m_cnt[k] = 0;
                m_idx[k]++;
                if (m_idx[k] == m_len[k]) begin
                    m_act[k] = 0;
                    frames_done++;
                    if (exp_q.size() > 0 && exp_q[0].inst == k)
                        check($sformatf("inst%0d back-to-back start", k), int'(tx[k]), 0);
                    else
                        check($sformatf("inst%0d idle after frame tx/busy", k),
                              int'({tx[k], busy[k]}), 2);
                end
            end
            if (m_act[k])
                check($sformatf("inst%0d bit%0d", k, m_idx[k]), int'(tx[k]),
                      int'(m_bits[k][m_idx[k]]));
        end
        if (!m_act[k] && tx[k] == 1'b0) begin
            if (exp_q.size() > 0 && exp_q[0].inst == k) begin
                f = exp_q.pop_front();
                m_bits[k] = f.bits;
                m_len[k]  = f.len;
            end else begin
                check($sformatf("inst%0d unexpected start bit", k), 1, 0);
                m_bits[k] = 16'hFFFE;
                m_len[k]  = 10;
            end
            m_act[k] = 1;
            m_idx[k] = 0;
            m_cnt[k] = 0;
            check($sformatf("inst%0d start bit", k), int'(tx[k]), int'(m_bits[k][0]));
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) mon_step(k);
    end

    // Offer a word until accepted; the expected frame is queued at acceptance.
    task automatic send(input int k, input logic [7:0] w, input logic [15:0] bits,
                        input int len);
        int     n = 0;
        frame_t f;
        @(negedge clk);
        case (k)
            0: din_a = w;
            1: din_b = w[6:0];
            2: din_c = w;
            default: din_d = w;
        endcase
        val[k] = 1'b1;
        while (!rdy[k] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            check($sformatf("inst%0d send timeout", k), 0, 1);
        end else begin
            f.inst = k;
            f.bits = bits;
            f.len  = len;
            exp_q.push_back(f);
        end
        @(negedge clk);
        val[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || m_act[0] || m_act[1] || m_act[2] || m_act[3])
               && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain within cycle budget", int'(n < 20000), 1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        // Reset state of every instance.
        #12;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("inst%0d reset tx", k), int'(tx[k]), 1);
            check($sformatf("inst%0d reset busy", k), int'(busy[k]), 0);
            check($sformatf("inst%0d reset count", k), int'(cnt[k]), 0);
            check($sformatf("inst%0d reset ready", k), int'(rdy[k]), 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic 8N1 frame.
        send(0, 8'hA5, 16'({1'b1, 8'hA5, 1'b0}), 10);
        wait_idle();

        // 7-bit even parity: 0x55 has four ones, 0x07 three.
        send(1, 8'h55, 16'({1'b1, 1'b0, 7'h55, 1'b0}), 10);
        send(1, 8'h07, 16'({1'b1, 1'b1, 7'h07, 1'b0}), 10);
        wait_idle();

        // Odd parity with two stop bits: 0xFF has eight ones, 0x07 three.
        send(2, 8'hFF, 16'({2'b11, 1'b1, 8'hFF, 1'b0}), 12);
        send(2, 8'h07, 16'({2'b11, 1'b0, 8'h07, 1'b0}), 12);
        wait_idle();

        // Tick held high with OVERSAMPLE 2: every bit lasts two clocks.
        send(3, 8'h01, 16'({1'b1, 8'h01, 1'b0}), 10);
        wait_idle();

        // Fill: one frame in flight plus four buffered, then a push against a full FIFO.
        send(0, 8'h11, 16'({1'b1, 8'h11, 1'b0}), 10);
        send(0, 8'h22, 16'({1'b1, 8'h22, 1'b0}), 10);
        send(0, 8'h33, 16'({1'b1, 8'h33, 1'b0}), 10);
        send(0, 8'h44, 16'({1'b1, 8'h44, 1'b0}), 10);
        send(0, 8'h55, 16'({1'b1, 8'h55, 1'b0}), 10);
        check("full count", int'(cnt[0]), 4);
        check("full ready", int'(rdy[0]), 0);
        check("full busy", int'(busy[0]), 1);
        send(0, 8'h66, 16'({1'b1, 8'h66, 1'b0}), 10);
        check("refill count", int'(cnt[0]), 4);
        check("refill ready", int'(rdy[0]), 0);
        wait_idle();

        // Asynchronous reset in the middle of the data bits.
        send(0, 8'hC3, 16'({1'b1, 8'hC3, 1'b0}), 10);
        repeat (192) @(negedge clk);
        check("busy before reset", int'(busy[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset tx", int'(tx[0]), 1);
        check("async reset busy", int'(busy[0]), 0);
        check("async reset count", int'(cnt[0]), 0);
        check("async reset ready", int'(rdy[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("no resume after reset", int'(tx[0]), 1);
        send(0, 8'h3C, 16'({1'b1, 8'h3C, 1'b0}), 10);
        wait_idle();

        check("frames completed", frames_done, 13);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
